// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the parallel-in serial-out transmitter
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Bit-index counter width; never narrower than one bit.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - modulo-WIDTH bit index counter with load, enable and terminal count
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc,
    output logic          pre_tc
);

    assign tc     = (count == CW'(WIDTH - 1));
    assign pre_tc = (count == CW'(WIDTH - 2));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with framing markers
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             tc;
    logic             pre_tc;
    logic             accept;
    logic             first_bit;
    logic             next_bit;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk    (clk),
        .clr    (clr),
        .load   (accept),
        .en     (state == SHIFT),
        .count  (count),
        .tc     (tc),
        .pre_tc (pre_tc)
    );

    // Accepting on the last-bit cycle is what gives zero-gap back-to-back words.
    assign p_ready   = (state == IDLE) || ((state == SHIFT) && tc);
    assign accept    = p_valid && p_ready;
    assign first_bit = MSB_FIRST ? p_in[WIDTH-1]  : p_in[0];
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            shreg       <= '0;
            d_out       <= IDLE_LEVEL;
            d_valid     <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            shreg       <= p_in;
            d_out       <= first_bit;
            d_valid     <= 1'b1;
            frame_start <= 1'b1;
            done        <= 1'b0;
            busy        <= 1'b1;
        end else if (state == SHIFT) begin
            if (tc) begin
                state       <= IDLE;
                shreg       <= '0;
                d_out       <= IDLE_LEVEL;
                d_valid     <= 1'b0;
                frame_start <= 1'b0;
                done        <= 1'b0;
                busy        <= 1'b0;
            end else begin
                shreg       <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                d_out       <= next_bit;
                frame_start <= 1'b0;
                done        <= pre_tc;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer in both bit orders
module tb_piso_serializer;

    logic       clk;
    logic       clr;
    logic [3:0] m_p_in, l_p_in;
    logic       m_p_valid, l_p_valid;
    logic       m_p_ready, l_p_ready;
    logic       m_d_out, l_d_out;
    logic       m_d_valid, l_d_valid;
    logic       m_frame_start, l_frame_start;
    logic       m_done, l_done;
    logic       m_busy, l_busy;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    logic [2:0] q_m[$];
    logic [2:0] q_l[$];
    int m_run = 0, m_last_run = 0;
    int l_run = 0, l_last_run = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .clr(clr), .p_in(m_p_in), .p_valid(m_p_valid), .p_ready(m_p_ready),
        .d_out(m_d_out), .d_valid(m_d_valid), .frame_start(m_frame_start),
        .done(m_done), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_lsb (
        .clk(clk), .clr(clr), .p_in(l_p_in), .p_valid(l_p_valid), .p_ready(l_p_ready),
        .d_out(l_d_out), .d_valid(l_d_valid), .frame_start(l_frame_start),
        .done(l_done), .busy(l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [2:0] e;
            checks++;
            if (m_d_valid) begin
                m_run++;
                if (q_m.size() == 0) begin
                    errors++;
                    $display("FAIL msb_stream: unexpected bit d_out=%b, no bit was expected", m_d_out);
                end else begin
                    e = q_m.pop_front();
                    if ({m_d_out, m_frame_start, m_done, m_busy} !== {e, 1'b1}) begin
                        errors++;
                        $display("FAIL msb_stream: {d_out,frame_start,done,busy}=%b expected %b",
                                 {m_d_out, m_frame_start, m_done, m_busy}, {e, 1'b1});
                    end
                end
            end else begin
                if (m_run != 0) m_last_run = m_run;
                m_run = 0;
                if ({m_d_out, m_frame_start, m_done, m_busy} !== 4'b0000) begin
                    errors++;
                    $display("FAIL msb_idle: {d_out,frame_start,done,busy}=%b expected 0000",
                             {m_d_out, m_frame_start, m_done, m_busy});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [2:0] e;
            checks++;
            if (l_d_valid) begin
                l_run++;
                if (q_l.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_stream: unexpected bit d_out=%b, no bit was expected", l_d_out);
                end else begin
                    e = q_l.pop_front();
                    if ({l_d_out, l_frame_start, l_done, l_busy} !== {e, 1'b1}) begin
                        errors++;
                        $display("FAIL lsb_stream: {d_out,frame_start,done,busy}=%b expected %b",
                                 {l_d_out, l_frame_start, l_done, l_busy}, {e, 1'b1});
                    end
                end
            end else begin
                if (l_run != 0) l_last_run = l_run;
                l_run = 0;
                if ({l_d_out, l_frame_start, l_done, l_busy} !== 4'b1000) begin
                    errors++;
                    $display("FAIL lsb_idle: {d_out,frame_start,done,busy}=%b expected 1000",
                             {l_d_out, l_frame_start, l_done, l_busy});
                end
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge that shows the word's first bit.
    task automatic put_word(input bit sel, input logic [3:0] w, output int waits);
        for (int k = 0; k < 4; k++) begin
            logic b;
            b = sel ? w[k] : w[3-k];
            if (sel) q_l.push_back({b, k == 0, k == 3});
            else     q_m.push_back({b, k == 0, k == 3});
        end
        if (sel) begin l_p_in = w; l_p_valid = 1'b1; end
        else     begin m_p_in = w; m_p_valid = 1'b1; end
        waits = 0;
        while (!(sel ? l_p_ready : m_p_ready) && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        checks++;
        if (waits >= 20) begin
            errors++;
            $display("FAIL accept_timeout: p_ready stayed 0 for %0d cycles, required within 20", waits);
        end
        @(negedge clk);
        if (sel) begin l_p_valid = 1'b0; l_p_in = ~w; end
        else     begin m_p_valid = 1'b0; m_p_in = ~w; end
    endtask

    task automatic test_reset();
        clr = 1'b0; m_p_valid = 1'b0; l_p_valid = 1'b0; m_p_in = '0; l_p_in = '0;
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({m_d_out, m_d_valid, m_frame_start, m_done, m_busy, m_p_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_msb: outputs=%b expected 000001",
                     {m_d_out, m_d_valid, m_frame_start, m_done, m_busy, m_p_ready});
        end
        checks++;
        if ({l_d_out, l_d_valid, l_frame_start, l_done, l_busy, l_p_ready} !== 6'b100001) begin
            errors++;
            $display("FAIL reset_lsb: outputs=%b expected 100001",
                     {l_d_out, l_d_valid, l_frame_start, l_done, l_busy, l_p_ready});
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic drain_check(input string name, input int run_len);
        for (int i = 0; i < 40 && (q_m.size() != 0 || q_l.size() != 0 || m_d_valid || l_d_valid); i++)
            @(negedge clk);
        #1;
        checks++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d/%0d bits still pending, required 0", name, q_m.size(), q_l.size());
        end
        if (run_len > 0) begin
            checks++;
            if (m_last_run != run_len) begin
                errors++;
                $display("FAIL %s_run: consecutive valid bits=%0d required %0d", name, m_last_run, run_len);
            end
        end
    endtask

    task automatic test_single();
        int w;
        @(negedge clk);
        put_word(1'b0, 4'b1011, w);
        drain_check("single", 4);
    endtask

    task automatic test_back_to_back();
        int w0, w1;
        @(negedge clk);
        put_word(1'b0, 4'b1011, w0);
        put_word(1'b0, 4'b0110, w1);
        checks++;
        if (w1 != 3) begin
            errors++;
            $display("FAIL b2b_accept: second word waited %0d cycles, required 3", w1);
        end
        drain_check("b2b", 8);
    endtask

    task automatic test_lsb_first();
        int w;
        @(negedge clk);
        put_word(1'b1, 4'b1011, w);
        drain_check("lsb", 0);
        checks++;
        if (l_last_run != 4) begin
            errors++;
            $display("FAIL lsb_run: consecutive valid bits=%0d required 4", l_last_run);
        end
    endtask

    task automatic test_back_pressure();
        int w;
        @(negedge clk);
        put_word(1'b0, 4'b1011, w);
        m_p_in = 4'b1111; m_p_valid = 1'b1;
        checks++;
        if (m_p_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_bit0: p_ready=%b required 0", m_p_ready);
        end
        @(negedge clk);
        checks++;
        if (m_p_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_bit1: p_ready=%b required 0", m_p_ready);
        end
        m_p_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_p_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_bit2: p_ready=%b required 0", m_p_ready);
        end
        @(negedge clk);
        checks++;
        if (m_p_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_bit3: p_ready=%b required 1", m_p_ready);
        end
        drain_check("bp", 4);
    endtask

    task automatic test_clear_mid_word();
        int w;
        @(negedge clk);
        put_word(1'b0, 4'b1011, w);
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({m_d_out, m_d_valid, m_frame_start, m_done, m_busy, m_p_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL clr_async: outputs=%b expected 000001",
                     {m_d_out, m_d_valid, m_frame_start, m_done, m_busy, m_p_ready});
        end
        q_m.delete();
        @(negedge clk);
        clr = 1'b0;
        put_word(1'b0, 4'b0001, w);
        drain_check("clr_fresh", 4);
    endtask

    task automatic test_random();
        int w;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            put_word(i[0], 4'($urandom_range(0, 15)), w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain_check("random", 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_back_pressure();
        test_clear_mid_word();
        test_random();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
